// File: rtl/seq_det_if.sv
// Control/CSR and serial-stream bundle for seq_det_ctrl.
// The master drives config, session control and the bit stream; the slave reports status.
interface seq_det_if #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 8,
   parameter int TMO_W = 16
);
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [CNT_W-1:0] cfg_target;
   logic [TMO_W-1:0] cfg_timeout;
   logic             start;
   logic             abort;
   logic             signal;
   logic             signal_vld;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             busy;
   logic             done;
   logic             timeout_flag;

   modport master (
      output cfg_we, cfg_pattern, cfg_target, cfg_timeout, start, abort, signal, signal_vld,
      input  match, match_count, busy, done, timeout_flag
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_target, cfg_timeout, start, abort, signal, signal_vld,
      output match, match_count, busy, done, timeout_flag
   );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable overlapping Mealy pattern detector with session control:
// arm, fill history, count matches, end on match target or cycle timeout.
module seq_det_ctrl #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 8,
   parameter int TMO_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   seq_det_if.slave   bus
);
   localparam int FILL_W = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);
   localparam logic [CNT_W:0]    CNT_ONE   = (CNT_W+1)'(1);

   typedef enum logic [1:0] {IDLE, ARMED, DETECT, DONE} state_t;

   typedef struct packed {
      logic [PAT_W-1:0] pattern;
      logic [CNT_W-1:0] target;
      logic [TMO_W-1:0] timeout;
   } cfg_t;

   state_t            state_q, state_d;
   cfg_t              cfg_q, cfg_d;
   // Session copy: a start taken alongside cfg_we runs on the config held before that write.
   cfg_t              sess_q, sess_d;
   logic [PAT_W-2:0]  hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [TMO_W-1:0]  cyc_q, cyc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              tmo_q, tmo_d;

   logic [PAT_W-1:0]  win;
   logic              match_c;
   logic              tgt_hit;
   logic              tmo_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         sess_q  <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cyc_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         sess_q  <= sess_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cyc_q   <= cyc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      sess_d  = sess_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      cyc_d   = cyc_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      tmo_d   = tmo_q;
      win     = {hist_q, bus.signal};
      match_c = 1'b0;
      tgt_hit = 1'b0;
      tmo_hit = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (bus.cfg_we) begin
               cfg_d.pattern = bus.cfg_pattern;
               cfg_d.target  = bus.cfg_target;
               cfg_d.timeout = bus.cfg_timeout;
            end
            if (bus.abort) begin
               state_d = IDLE;
               done_d  = 1'b0;
               tmo_d   = 1'b0;
            end else if (bus.start) begin
               state_d = ARMED;
               sess_d  = cfg_q;
               hist_d  = '0;
               fill_d  = '0;
               cyc_d   = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
               tmo_d   = 1'b0;
            end
         end

         ARMED, DETECT: begin
            cyc_d   = cyc_q + TMO_W'(1);
            tmo_hit = (sess_q.timeout != '0) && (cyc_q == sess_q.timeout - TMO_W'(1));
            if (bus.signal_vld) begin
               hist_d = win[PAT_W-2:0];
               if (state_q == ARMED) begin
                  fill_d = fill_q + FILL_W'(1);
                  if (fill_q == FILL_LAST) state_d = DETECT;
               end else if (win == sess_q.pattern) begin
                  // History is never cleared on a hit, so overlapping matches are seen.
                  match_c = !rst;
                  cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                  tgt_hit = (sess_q.target != '0) &&
                            (({1'b0, cnt_q} + CNT_ONE) == {1'b0, sess_q.target});
               end
            end
            if (bus.abort) begin
               state_d = IDLE;
            end else if (tgt_hit) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (tmo_hit) begin
               state_d = DONE;
               tmo_d   = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.match        = match_c;
   assign bus.match_count  = cnt_q;
   assign bus.busy         = (state_q == ARMED) || (state_q == DETECT);
   assign bus.done         = done_q;
   assign bus.timeout_flag = tmo_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Vector-table and hand-sequence bench for seq_det_ctrl with an expected-result queue.
module tb_seq_det_ctrl;
   localparam int PAT_W = 3;
   localparam int CNT_W = 8;
   localparam int TMO_W = 16;

   typedef struct {
      string            nm;
      bit               rst;
      bit               we;
      logic [PAT_W-1:0] pat;
      logic [CNT_W-1:0] tgt;
      logic [TMO_W-1:0] tmo;
      bit               st;
      bit               ab;
      bit               sig;
      bit               vld;
      bit               em;
      int               ecnt;
      bit               eb;
      bit               ed;
      bit               et;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   seq_det_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

   seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t vc(string nm, bit r, bit we, logic [PAT_W-1:0] pat, logic [CNT_W-1:0] tgt,
                               logic [TMO_W-1:0] tmo, bit st, bit ab, bit sig, bit vld,
                               bit em, int ecnt, bit eb, bit ed, bit et);
      vec_t v;
      v.nm = nm; v.rst = r; v.we = we; v.pat = pat; v.tgt = tgt; v.tmo = tmo;
      v.st = st; v.ab = ab; v.sig = sig; v.vld = vld;
      v.em = em; v.ecnt = ecnt; v.eb = eb; v.ed = ed; v.et = et;
      return v;
   endfunction

   function automatic vec_t vb(string nm, bit sig, bit vld, bit em, int ecnt, bit eb, bit ed, bit et);
      return vc(nm, 0, 0, '0, '0, '0, 0, 0, sig, vld, em, ecnt, eb, ed, et);
   endfunction

   task automatic chk(string nm, string f, int got, int want);
      if (got != want) begin
         n_err++;
         $display("FAIL %s %s: got %0d expected %0d", nm, f, got, want);
      end
   endtask

   // Drive one cycle; match is checked mid-cycle, registered outputs after the edge from the queue.
   task automatic apply(vec_t v);
      vec_t e;
      rst             = v.rst;
      bus.cfg_we      = v.we;
      bus.cfg_pattern = v.pat;
      bus.cfg_target  = v.tgt;
      bus.cfg_timeout = v.tmo;
      bus.start       = v.st;
      bus.abort       = v.ab;
      bus.signal      = v.sig;
      bus.signal_vld  = v.vld;
      exp_q.push_back(v);
      n_vec++;
      @(negedge clk);
      chk(v.nm, "match", int'(bus.match), int'(v.em));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk(e.nm, "match_count", int'(bus.match_count), e.ecnt);
      chk(e.nm, "busy", int'(bus.busy), int'(e.eb));
      chk(e.nm, "done", int'(bus.done), int'(e.ed));
      chk(e.nm, "timeout_flag", int'(bus.timeout_flag), int'(e.et));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_target = '0; bus.cfg_timeout = '0;
      bus.start = 0; bus.abort = 0; bus.signal = 0; bus.signal_vld = 0;

      // Reset, basic overlapping detection, mid-stream reset
      tbl.push_back(vc("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(vc("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(vc("b_cfg", 0, 1, 3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(vc("b_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("b_bit1", 1, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("b_bit2", 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("b_bit3", 1, 1, 1, 1, 1, 0, 0));
      tbl.push_back(vb("b_bit4", 0, 1, 0, 1, 1, 0, 0));
      tbl.push_back(vb("b_bit5", 1, 1, 1, 2, 1, 0, 0));
      tbl.push_back(vb("b_bit6", 0, 1, 0, 2, 1, 0, 0));
      tbl.push_back(vc("c_rst0", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(vc("c_rst1", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      // Cleared config: pattern 000, no target, no timeout
      tbl.push_back(vc("d_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("d_bit1", 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("d_bit2", 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("d_bit3", 0, 1, 1, 1, 1, 0, 0));
      tbl.push_back(vc("d_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      // Gaps in signal_vld
      tbl.push_back(vc("e_cfg", 0, 1, 3'b101, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(vc("e_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("e_bit1", 1, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("e_gap1", 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("e_gap2", 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("e_gap3", 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("e_bit2", 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("e_gap4", 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("e_bit3", 1, 1, 1, 1, 1, 0, 0));
      tbl.push_back(vc("e_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      // Target of 2 ends the session; bits in DONE are ignored
      tbl.push_back(vc("f_cfg", 0, 1, 3'b101, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(vc("f_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(vb("f_bit1", 1, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("f_bit2", 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(vb("f_bit3", 1, 1, 1, 1, 1, 0, 0));
      tbl.push_back(vb("f_bit4", 0, 1, 0, 1, 1, 0, 0));
      tbl.push_back(vb("f_bit5", 1, 1, 1, 2, 0, 1, 0));
      tbl.push_back(vb("f_bit6", 0, 1, 0, 2, 0, 1, 0));
      tbl.push_back(vb("f_bit7", 1, 1, 0, 2, 0, 1, 0));

      @(posedge clk);
      #1;
      foreach (tbl[i]) apply(tbl[i]);

      // Timeout of 10 on an all-zero stream, config written while in DONE
      apply(vc("g_cfg", 0, 1, 3'b101, 0, 10, 0, 0, 0, 0, 0, 2, 0, 1, 0));
      apply(vc("g_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i < 10; i++)
         apply(vb($sformatf("g_cyc%0d", i + 1), 0, 1, 0, 0, (i < 9), 0, (i == 9)));
      apply(vc("g_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      // Target hit and timeout on the same cycle: done wins
      apply(vc("h_cfg", 0, 1, 3'b101, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      apply(vc("h_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      apply(vb("h_bit1", 1, 1, 0, 0, 1, 0, 0));
      apply(vb("h_bit2", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("h_bit3", 1, 1, 1, 1, 0, 1, 0));
      apply(vc("h_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

      // start with cfg_we in the same cycle runs on the previous config
      apply(vc("i_cfg", 0, 1, 3'b101, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      apply(vc("i_cfgst", 0, 1, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      apply(vb("i_bit1", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("i_bit2", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("i_bit3", 0, 1, 0, 0, 1, 0, 0));
      apply(vc("i_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      apply(vc("i_start2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      apply(vb("i2_bit1", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("i2_bit2", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("i2_bit3", 0, 1, 1, 1, 1, 0, 0));
      apply(vc("i2_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

      // Abort in DETECT on a matching bit with a config write: match counted, config kept
      apply(vc("j_cfg", 0, 1, 3'b101, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      apply(vc("j_start", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      apply(vb("j_bit1", 1, 1, 0, 0, 1, 0, 0));
      apply(vb("j_bit2", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("j_bit3", 1, 1, 1, 1, 1, 0, 0));
      apply(vb("j_bit4", 0, 1, 0, 1, 1, 0, 0));
      apply(vc("j_abortwe", 0, 1, 3'b010, 0, 0, 0, 1, 1, 1, 1, 2, 0, 0, 0));
      apply(vc("j_start2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      apply(vb("j2_bit1", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("j2_bit2", 1, 1, 0, 0, 1, 0, 0));
      apply(vb("j2_bit3", 0, 1, 0, 0, 1, 0, 0));
      apply(vb("j2_bit4", 1, 1, 1, 1, 1, 0, 0));
      apply(vc("j2_abort", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
